// File: rtl/datapath_core.sv
// datapath_core: interrupt-driven 16-bit I/O datapath.
//
// Four host-written mailboxes feed a single accumulator (ACC). Rising edges
// on int0..int3 latch pending bits; one pending source is serviced per clock
// in fixed priority (0 highest). Each service applies that source's ALU op
// to ACC and publishes the result on lcdWData with a one-cycle syscallW.
//
// Ports:
//   CLK        - system clock, rising-edge active
//   Reset      - asynchronous active-low reset
//   intWrite   - mailbox write enable
//   int0..int3 - interrupt lines (int0 highest priority)
//   intDataIn  - mailbox write data
//   intLvl1/0  - mailbox select {intLvl1,intLvl0}
//   intr       - OR of pending bits (combinational)
//   intDataOut - mailbox value used by the last service
//   lcdWData   - ACC result of the last service
//   syscallW   - one-cycle strobe marking a new lcdWData

module datapath_core #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             intWrite,
  input  logic             int0,
  input  logic             int1,
  input  logic             int2,
  input  logic             int3,
  input  logic [WIDTH-1:0] intDataIn,
  input  logic             intLvl1,
  input  logic             intLvl0,
  output logic             intr,
  output logic [WIDTH-1:0] intDataOut,
  output logic [WIDTH-1:0] lcdWData,
  output logic             syscallW
);

  logic [WIDTH-1:0] mbox_q [4];
  logic [WIDTH-1:0] acc_q;
  logic [3:0]       pend_q, pend_d;
  logic [3:0]       prev_q;
  logic [WIDTH-1:0] data_out_q;
  logic [WIDTH-1:0] lcd_q;
  logic             syscall_q;

  logic [3:0]       int_vec;
  logic [3:0]       rise;
  logic             svc;
  logic [1:0]       sel;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] acc_new;
  logic [1:0]       wr_sel;

  assign int_vec = {int3, int2, int1, int0};
  assign wr_sel  = {intLvl1, intLvl0};

  always_comb begin
    rise = int_vec & ~prev_q;
    svc  = |pend_q;

    // Lowest index wins.
    sel = 2'd3;
    if (pend_q[0])      sel = 2'd0;
    else if (pend_q[1]) sel = 2'd1;
    else if (pend_q[2]) sel = 2'd2;

    // Read the pre-edge mailbox so a same-edge write does not affect service.
    operand = mbox_q[sel];

    acc_new = acc_q;
    unique case (sel)
      2'd0: acc_new = acc_q + operand;
      2'd1: acc_new = acc_q - operand;
      2'd2: acc_new = acc_q ^ operand;
      2'd3: acc_new = operand;
      default: acc_new = acc_q;
    endcase

    // Clear the serviced bit first, then OR in new rises so a same-edge
    // rise on the serviced source keeps it pending.
    pend_d = pend_q;
    if (svc) pend_d[sel] = 1'b0;
    pend_d = pend_d | rise;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 4; i++) mbox_q[i] <= '0;
      acc_q      <= '0;
      pend_q     <= '0;
      prev_q     <= '0;
      data_out_q <= '0;
      lcd_q      <= '0;
      syscall_q  <= 1'b0;
    end else begin
      prev_q    <= int_vec;
      pend_q    <= pend_d;
      syscall_q <= svc;
      if (intWrite) mbox_q[wr_sel] <= intDataIn;
      if (svc) begin
        acc_q      <= acc_new;
        data_out_q <= operand;
        lcd_q      <= acc_new;
      end
    end
  end

  assign intr       = |pend_q;
  assign intDataOut = data_out_q;
  assign lcdWData   = lcd_q;
  assign syscallW   = syscall_q;

endmodule

// File: tb/tb_datapath_core.sv
module tb_datapath_core;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        intWrite;
  logic [3:0]  ints;
  logic [15:0] intDataIn;
  logic [1:0]  lvl;
  logic        intr;
  logic [15:0] intDataOut;
  logic [15:0] lcdWData;
  logic        syscallW;

  int n_vec = 0;
  int n_err = 0;

  datapath_core #(.WIDTH(16)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .intWrite  (intWrite),
    .int0      (ints[0]),
    .int1      (ints[1]),
    .int2      (ints[2]),
    .int3      (ints[3]),
    .intDataIn (intDataIn),
    .intLvl1   (lvl[1]),
    .intLvl0   (lvl[0]),
    .intr      (intr),
    .intDataOut(intDataOut),
    .lcdWData  (lcdWData),
    .syscallW  (syscallW)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  logic [15:0] m_mbox [4];
  logic [15:0] m_acc, m_out, m_lcd;
  bit          m_pend [4];
  bit          m_prev [4];
  bit          m_sys;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_mbox[i] = 16'h0; m_pend[i] = 0; m_prev[i] = 0;
    end
    m_acc = 0; m_out = 0; m_lcd = 0; m_sys = 0;
  endtask

  function automatic bit model_intr();
    return m_pend[0] | m_pend[1] | m_pend[2] | m_pend[3];
  endfunction

  // One clock edge as the behaviour is described: service the highest-priority
  // job outstanding before the edge, then record new rises, then store writes.
  task automatic model_edge();
    int srv = -1;
    for (int k = 0; k < 4; k++) if (m_pend[k] && srv < 0) srv = k;
    m_sys = (srv >= 0);
    if (srv >= 0) begin
      case (srv)
        0: m_acc = m_acc + m_mbox[0];
        1: m_acc = m_acc - m_mbox[1];
        2: m_acc = m_acc ^ m_mbox[2];
        default: m_acc = m_mbox[3];
      endcase
      m_out = m_mbox[srv];
      m_lcd = m_acc;
      m_pend[srv] = 0;
    end
    for (int n = 0; n < 4; n++) begin
      if (ints[n] && !m_prev[n]) m_pend[n] = 1;
      m_prev[n] = ints[n];
    end
    if (intWrite) m_mbox[lvl] = intDataIn;
  endtask

  task automatic check_all();
    check("intr",       {15'h0, intr},     {15'h0, model_intr()});
    check("syscallW",   {15'h0, syscallW}, {15'h0, m_sys});
    check("lcdWData",   lcdWData,          m_lcd);
    check("intDataOut", intDataOut,        m_out);
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    intWrite = 0; ints = 4'b0000;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [15:0] d);
    intWrite = 1; lvl = sel; intDataIn = d;
    step();
    intWrite = 0;
  endtask

  // Raise the lines in mask for one cycle, then let them settle until idle.
  task automatic pulse(input logic [3:0] mask);
    ints = mask;
    step();
    ints = 4'b0000;
    for (int i = 0; i < 5; i++) step();
  endtask

  int svc_cnt;

  initial begin
    Reset = 0; intWrite = 0; ints = 0; intDataIn = 0; lvl = 0;
    model_reset();
    #20;
    Reset = 1;
    #1;
    check("rst_intr", {15'h0, intr}, 16'h0);
    check("rst_sys",  {15'h0, syscallW}, 16'h0);
    check("rst_lcd",  lcdWData, 16'h0000);
    check("rst_out",  intDataOut, 16'h0000);
    @(negedge CLK);

    // Add path with explicit latency checks
    wr(2'd0, 16'h0005);
    ints = 4'b0001;
    step();
    check("add_intr", {15'h0, intr}, 16'h1);
    check("add_nosys", {15'h0, syscallW}, 16'h0);
    ints = 4'b0000;
    step();
    check("add_sys", {15'h0, syscallW}, 16'h1);
    check("add_lcd", lcdWData, 16'h0005);
    check("add_out", intDataOut, 16'h0005);
    check("add_intr_lo", {15'h0, intr}, 16'h0);
    step();
    check("add_sys_1cyc", {15'h0, syscallW}, 16'h0);
    pulse(4'b0001);
    check("add2_lcd", lcdWData, 16'h000A);

    // Wrap
    wr(2'd3, 16'hFFFF);
    wr(2'd0, 16'h0001);
    pulse(4'b1000);
    check("load_ffff", lcdWData, 16'hFFFF);
    pulse(4'b0001);
    check("wrap_add", lcdWData, 16'h0000);
    wr(2'd1, 16'h0001);
    pulse(4'b0010);
    check("wrap_sub", lcdWData, 16'hFFFF);

    // Priority: int2 and int3 together
    wr(2'd2, 16'h00F0);
    wr(2'd3, 16'h1234);
    ints = 4'b1100;
    step();
    ints = 4'b0000;
    step();
    check("prio_xor", lcdWData, 16'hFF0F);
    check("prio_sys1", {15'h0, syscallW}, 16'h1);
    check("prio_intr_mid", {15'h0, intr}, 16'h1);
    step();
    check("prio_load", lcdWData, 16'h1234);
    check("prio_sys2", {15'h0, syscallW}, 16'h1);
    check("prio_intr_lo", {15'h0, intr}, 16'h0);
    step();

    // Level hold: one service for a held line, another after re-raise
    svc_cnt = 0;
    ints = 4'b0010;
    for (int i = 0; i < 10; i++) begin step(); if (syscallW) svc_cnt++; end
    ints = 4'b0000;
    for (int i = 0; i < 3; i++) begin step(); if (syscallW) svc_cnt++; end
    check("hold_once", svc_cnt[15:0], 16'd1);
    ints = 4'b0010;
    for (int i = 0; i < 3; i++) begin step(); if (syscallW) svc_cnt++; end
    ints = 4'b0000;
    check("hold_twice", svc_cnt[15:0], 16'd2);
    for (int i = 0; i < 3; i++) step();

    // Collision: write mailbox0 on the edge that services int0
    wr(2'd3, 16'h0000);
    pulse(4'b1000);
    wr(2'd0, 16'h0002);
    ints = 4'b0001;
    step();
    ints = 4'b0000;
    intWrite = 1; lvl = 2'd0; intDataIn = 16'h0009;
    step();
    intWrite = 0;
    check("coll_old", lcdWData, 16'h0002);
    for (int i = 0; i < 3; i++) step();
    pulse(4'b0001);
    check("coll_new", lcdWData, 16'h000B);

    // Async reset while int2 pending
    ints = 4'b0100;
    step();
    ints = 4'b0000;
    check("ar_pend", {15'h0, intr}, 16'h1);
    #2 Reset = 0;
    #1;
    check("ar_intr", {15'h0, intr}, 16'h0);
    check("ar_lcd", lcdWData, 16'h0000);
    model_reset();
    #2 Reset = 1;
    svc_cnt = 0;
    for (int i = 0; i < 4; i++) begin step(); if (syscallW) svc_cnt++; end
    check("ar_nosvc", svc_cnt[15:0], 16'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      intWrite  = ($urandom_range(0, 3) == 0);
      lvl       = 2'($urandom_range(0, 3));
      intDataIn = 16'($urandom);
      for (int n = 0; n < 4; n++) ints[n] = ($urandom_range(0, 2) == 0);
      step();
    end
    idle();
    for (int i = 0; i < 6; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/datapath_core.md
Name: datapath_core

Overview:
- 16-bit interrupt-driven I/O datapath for the 16-bit processor.
- Holds four per-source 16-bit mailboxes, written by the host port, and a 16-bit accumulator (ACC).
- Detects rising edges on four interrupt lines, services pending interrupts in fixed priority, and applies a per-source ALU operation to ACC.
- Each result goes to the LCD write-data port with a one-cycle syscall write strobe.

Parameters:
- WIDTH, 16, data width of mailboxes, ACC and all data ports.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- intWrite  input  1  mailbox write enable.
- int0  input  1  interrupt line 0 (highest priority).
- int1  input  1  interrupt line 1.
- int2  input  1  interrupt line 2.
- int3  input  1  interrupt line 3 (lowest priority).
- intDataIn  input  16  mailbox write data.
- intLvl1  input  1  mailbox select, MSB.
- intLvl0  input  1  mailbox select, LSB.
- intr  output  1  combinational OR of the pending[3:0] bits.
- intDataOut  output  16  mailbox value used by the last serviced interrupt.
- lcdWData  output  16  ACC result of the last serviced interrupt.
- syscallW  output  1  one-cycle strobe marking a new lcdWData value.

Behaviour:
- Reset (Reset=0, asynchronous) clears:
  - mailboxes 0-3, ACC, pending[3:0], edge-history flops;
  - intDataOut, lcdWData and syscallW (all 0); intr therefore 0.
- All inputs are synchronous to CLK; there is no internal synchronizer.
- Mailbox write: on a rising edge with intWrite=1, mailbox[{intLvl1,intLvl0}] <= intDataIn.
- Edge detect: each line has a history flop prev[n] <= intN every cycle. rise[n] = intN & ~prev[n].
  - A rise sets pending[n] at that edge.
  - A line held high sets pending only once; it must go low and high again to re-interrupt.
- Service: on any rising edge where pending != 0 (value before this edge), select the lowest index k with pending[k]=1, then in the same edge:
  - src 0: ACC <= ACC + mailbox[0]
  - src 1: ACC <= ACC - mailbox[1]
  - src 2: ACC <= ACC ^ mailbox[2]
  - src 3: ACC <= mailbox[3] (load)
  - pending[k] <= 0; intDataOut <= mailbox[k]; lcdWData <= new ACC; syscallW <= 1.
- Only one interrupt is serviced per cycle. syscallW is 0 on every edge where nothing is serviced.
- Arithmetic is modulo 2^16 (wrap, no flags). 0xFFFF+1 = 0x0000; 0x0000-1 = 0xFFFF.
- Latency: a rise seen at edge N sets pending at N, is serviced at edge N+1, and syscallW is high for the cycle after N+1. intr is high for the cycle between N and N+1 when it is the only pending source.
- Simultaneous events:
  - A new rise on source k in the same edge that services k: the set wins, so pending[k] stays 1 and k is serviced again later.
  - A mailbox write to mailbox[k] in the same edge that services k: service uses the old value; the new value is stored.
  - Several rises in one edge are serviced in order 0,1,2,3 on consecutive edges, with syscallW high for consecutive cycles.
- Reset mid-service drops all pending work; nothing is serviced after release until new rises occur.
- Outputs intDataOut and lcdWData hold their values between services.

Test Plan:
- Reset: Reset=0 for 20 ns, then 1 -> intr=0, syscallW=0, lcdWData=0x0000, intDataOut=0x0000.
- Add path: write mailbox0=0x0005 (lvl=00) -> pulse int0 -> intr=1 for one cycle, then syscallW=1 for one cycle, lcdWData=0x0005, intDataOut=0x0005.
  - Pulse int0 again -> lcdWData=0x000A.
- Wrap: mailbox3=0xFFFF, mailbox0=0x0001. Pulse int3 -> lcdWData=0xFFFF. Pulse int0 -> lcdWData=0x0000.
  - Mailbox1=0x0001 with ACC=0 -> pulse int1 -> lcdWData=0xFFFF.
- Priority: mailbox2=0x00F0, mailbox3=0x1234. Raise int3 and int2 in the same cycle -> first service XOR (ACC^0x00F0), next cycle load 0x1234. syscallW high 2 consecutive cycles; intr falls after the second service.
- Level hold: hold int1 high for 10 cycles -> exactly one service. Drop and re-raise -> a second service.
- Collision: intWrite to mailbox0 with 0x0009 in the same edge int0 is serviced (old value 0x0002, ACC=0) -> lcdWData=0x0002; the next int0 pulse gives 0x000B.
- Async reset: assert Reset=0 between edges while int2 is pending -> intr drops immediately; no syscallW after release.
